// File: rtl/uart_rx_ext_if.sv
// Receive-side bundle for uart_rx_ext: serial line in, frame holding register out.
interface uart_rx_ext_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  rx_data;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  rx_busy;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun_err;
    logic                  break_det;

    // Receiver: samples the line, presents frames and status
    modport master (
        input  rx_data,
        input  rx_ready,
        output rx_byte,
        output rx_valid,
        output rx_busy,
        output parity_err,
        output frame_err,
        output overrun_err,
        output break_det
    );

    // Line driver and frame consumer
    modport slave (
        output rx_data,
        output rx_ready,
        input  rx_byte,
        input  rx_valid,
        input  rx_busy,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        input  break_det
    );
endinterface

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: oversampled 3-sample majority vote, optional parity,
// 1 or 2 stop bits, parity/framing/overrun/break reporting, valid/ready holding register.
// Legal configuration: DATA_WIDTH 5..9, PARITY 0/1/2, STOP_BITS 1/2, OVERSAMPLE even and >= 8,
// CLK_FREQ >= BAUD_RATE*OVERSAMPLE.
module uart_rx_ext #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic          clk,
    input  logic          areset,
    uart_rx_ext_if.master bus
);

    localparam int unsigned TICKS_PER_SAMPLE = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned PRESC_W  = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;
    localparam int unsigned SCNT_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W   = $clog2(DATA_WIDTH);
    localparam int unsigned VOTE_LO  = OVERSAMPLE / 2 - 1;
    localparam int unsigned VOTE_MID = OVERSAMPLE / 2;
    localparam int unsigned VOTE_HI  = OVERSAMPLE / 2 + 1;
    localparam int unsigned BIT_LAST = OVERSAMPLE - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  line_prev_q;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [SCNT_W-1:0]     scnt_q, scnt_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [1:0]            votes_q, votes_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ones_q, ones_d;
    logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
    logic                  valid_q, valid_d;
    logic                  perr_out_q, perr_out_d;
    logic                  ferr_out_q, ferr_out_d;
    logic                  busy_q, busy_d;
    logic                  ovr_q, ovr_d;
    logic                  brk_q, brk_d;

    logic                  line_c;
    logic                  fall_c;
    logic                  tick_c;
    logic                  vote_pt_c;
    logic                  bit_end_c;
    logic                  voted_c;
    logic                  par_x_c;

    // Sampling strobes and majority vote (first two samples held in votes_q, third is the live line)
    always_comb begin
        line_c    = sync_q[1];
        fall_c    = line_prev_q & ~line_c;
        tick_c    = (presc_q == PRESC_W'(TICKS_PER_SAMPLE - 1));
        vote_pt_c = tick_c && (scnt_q == SCNT_W'(VOTE_HI));
        bit_end_c = tick_c && (scnt_q == SCNT_W'(BIT_LAST));
        voted_c   = votes_q[1] | (votes_q[0] & line_c);
        par_x_c   = (^shift_q) ^ voted_c;
    end

    // Next-state, counters, frame accumulation and output register updates
    always_comb begin
        state_d    = state_q;
        presc_d    = tick_c ? '0 : presc_q + 1'b1;
        scnt_d     = scnt_q;
        bcnt_d     = bcnt_q;
        stop_cnt_d = stop_cnt_q;
        votes_d    = votes_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ones_d     = ones_q;
        rx_byte_d  = rx_byte_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        valid_d    = valid_q && !bus.rx_ready;
        ovr_d      = 1'b0;
        brk_d      = 1'b0;

        if (tick_c) begin
            scnt_d = bit_end_c ? '0 : scnt_q + 1'b1;
            if (scnt_q == SCNT_W'(VOTE_LO)) begin
                votes_d = {1'b0, line_c};
            end else if (scnt_q == SCNT_W'(VOTE_MID)) begin
                votes_d = votes_q + {1'b0, line_c};
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Only a true 1->0 edge starts a frame; a line stuck low never retriggers
                if (fall_c) begin
                    state_d    = ST_START;
                    presc_d    = '0;
                    scnt_d     = '0;
                    bcnt_d     = '0;
                    stop_cnt_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    ones_d     = 1'b0;
                end
            end
            ST_START: begin
                if (vote_pt_c && voted_c) begin
                    state_d = ST_IDLE;
                end else if (bit_end_c) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (vote_pt_c) begin
                    shift_d = {voted_c, shift_q[DATA_WIDTH-1:1]};
                    ones_d  = ones_q | voted_c;
                end
                if (bit_end_c) begin
                    if (bcnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (vote_pt_c) begin
                    perr_d = (PARITY == 1) ? ~par_x_c : par_x_c;
                    ones_d = ones_q | voted_c;
                end
                if (bit_end_c) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at the vote point of the last stop bit so a back-to-back start edge is seen
                if (vote_pt_c) begin
                    ferr_d = ferr_q | ~voted_c;
                    ones_d = ones_q | voted_c;
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        if (!(ones_q || voted_c)) begin
                            brk_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end else if (bit_end_c) begin
                    stop_cnt_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!valid_q || bus.rx_ready) begin
                    rx_byte_d  = shift_q;
                    perr_out_d = perr_q;
                    ferr_out_d = ferr_q;
                    valid_d    = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
            presc_q     <= '0;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            stop_cnt_q  <= 1'b0;
            votes_q     <= '0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ones_q      <= 1'b0;
            rx_byte_q   <= '0;
            valid_q     <= 1'b0;
            perr_out_q  <= 1'b0;
            ferr_out_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], bus.rx_data};
            line_prev_q <= line_c;
            presc_q     <= presc_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            stop_cnt_q  <= stop_cnt_d;
            votes_q     <= votes_d;
            shift_q     <= shift_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ones_q      <= ones_d;
            rx_byte_q   <= rx_byte_d;
            valid_q     <= valid_d;
            perr_out_q  <= perr_out_d;
            ferr_out_q  <= ferr_out_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            brk_q       <= brk_d;
        end
    end

    assign bus.rx_byte     = rx_byte_q;
    assign bus.rx_valid    = valid_q;
    assign bus.rx_busy     = busy_q;
    assign bus.parity_err  = perr_out_q;
    assign bus.frame_err   = ferr_out_q;
    assign bus.overrun_err = ovr_q;
    assign bus.break_det   = brk_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1 instance and an 8E1 instance at 16 clocks per bit,
// frames checked through a scoreboard of expected {byte, parity_err, frame_err}.
module tb_uart_rx_ext;

    localparam int unsigned DW       = 8;
    localparam int unsigned BIT_CLKS = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    logic clk = 1'b0;
    logic areset;

    uart_rx_ext_if #(.DATA_WIDTH(DW)) bus_n ();
    uart_rx_ext_if #(.DATA_WIDTH(DW)) bus_e ();

    uart_rx_ext #(
        .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(DW),
        .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)
    ) dut_n (
        .clk(clk), .areset(areset), .bus(bus_n)
    );

    uart_rx_ext #(
        .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(DW),
        .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)
    ) dut_e (
        .clk(clk), .areset(areset), .bus(bus_e)
    );

    always #5 clk = ~clk;

    exp_t        q_n[$];
    exp_t        q_e[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned vcyc [2];
    int unsigned ovr  [2];
    int unsigned brk  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Count status pulses and pop/compare a scoreboard entry on every accepted frame
    task automatic observe(input bit sel, input logic valid, input logic ready, input logic ov,
                           input logic bk, input logic [DW-1:0] rbyte, input logic pe, input logic fe);
        exp_t  e;
        bit    pend;
        string pfx;
        pfx = sel ? "e_" : "n_";
        if (valid) vcyc[sel]++;
        if (ov)    ovr[sel]++;
        if (bk)    brk[sel]++;
        if (valid && ready) begin
            pend = sel ? (q_e.size() != 0) : (q_n.size() != 0);
            check_eq({pfx, "frame_expected"}, 32'(pend), 32'd1);
            if (pend) begin
                if (sel) e = q_e.pop_front();
                else     e = q_n.pop_front();
                check_eq({pfx, "rx_byte"}, 32'(rbyte), 32'(e.data));
                check_eq({pfx, "parity_err"}, 32'(pe), 32'(e.perr));
                check_eq({pfx, "frame_err"}, 32'(fe), 32'(e.ferr));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!areset) begin
            observe(1'b0, bus_n.rx_valid, bus_n.rx_ready, bus_n.overrun_err, bus_n.break_det,
                    bus_n.rx_byte, bus_n.parity_err, bus_n.frame_err);
            observe(1'b1, bus_e.rx_valid, bus_e.rx_ready, bus_e.overrun_err, bus_e.break_det,
                    bus_e.rx_byte, bus_e.parity_err, bus_e.frame_err);
        end
    end

    // Drive a line level for nclk clocks; called and returns just after a rising edge
    task automatic hold(input bit sel, input logic b, input int unsigned nclk);
        if (sel) bus_e.rx_data = b;
        else     bus_n.rx_data = b;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    // Send one frame (even parity bit on the 8E1 line), optionally expecting it to be delivered
    task automatic send(input bit sel, input logic [DW-1:0] data, input logic bad_par,
                        input logic stop_bit, input logic deliver);
        exp_t e;
        e.data = data;
        e.perr = sel ? bad_par : 1'b0;
        e.ferr = ~stop_bit;
        if (deliver) begin
            if (sel) q_e.push_back(e);
            else     q_n.push_back(e);
        end
        hold(sel, 1'b0, BIT_CLKS);
        for (int i = 0; i < int'(DW); i++) hold(sel, data[i], BIT_CLKS);
        if (sel) hold(sel, (^data) ^ bad_par, BIT_CLKS);
        hold(sel, stop_bit, BIT_CLKS);
        if (sel) bus_e.rx_data = 1'b1;
        else     bus_n.rx_data = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, n_checks=%0d expected end", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned v0, o0, b0;
        for (int i = 0; i < 2; i++) begin
            vcyc[i] = 0; ovr[i] = 0; brk[i] = 0;
        end
        areset         = 1'b1;
        bus_n.rx_data  = 1'b1;
        bus_e.rx_data  = 1'b1;
        bus_n.rx_ready = 1'b1;
        bus_e.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("n_reset_outputs", 32'({bus_n.rx_byte, bus_n.rx_valid, bus_n.rx_busy, bus_n.parity_err,
                 bus_n.frame_err, bus_n.overrun_err, bus_n.break_det}), 32'd0);
        check_eq("e_reset_outputs", 32'({bus_e.rx_byte, bus_e.rx_valid, bus_e.rx_busy, bus_e.parity_err,
                 bus_e.frame_err, bus_e.overrun_err, bus_e.break_det}), 32'd0);
        @(posedge clk);
        #1 areset = 1'b0;
        hold(0, 1'b1, 8);

        // 8N1 basic frame
        v0 = vcyc[0];
        send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        hold(0, 1'b1, 32);
        check_eq("n_valid_cycles", vcyc[0] - v0, 32'd1);
        check_eq("n_busy_after_done", 32'(bus_n.rx_busy), 32'd0);

        // 8E1 good and bad parity, back to back
        send(1, 8'h03, 1'b0, 1'b1, 1'b1);
        send(1, 8'h03, 1'b1, 1'b1, 1'b1);
        hold(1, 1'b1, 32);

        // Framing error, then break, then a clean frame
        send(1, 8'h55, 1'b0, 1'b0, 1'b1);
        hold(1, 1'b1, 32);
        v0 = vcyc[1]; b0 = brk[1]; o0 = ovr[1];
        hold(1, 1'b0, 12 * BIT_CLKS);
        hold(1, 1'b1, 32);
        check_eq("e_break_pulse_cycles", brk[1] - b0, 32'd1);
        check_eq("e_break_no_valid", vcyc[1] - v0, 32'd0);
        check_eq("e_break_no_overrun", ovr[1] - o0, 32'd0);
        send(1, 8'h3C, 1'b0, 1'b1, 1'b1);
        hold(1, 1'b1, 32);

        // Glitch rejection
        v0 = vcyc[1]; b0 = brk[1]; o0 = ovr[1];
        hold(1, 1'b0, 3);
        hold(1, 1'b1, 0);
        check_eq("e_glitch_busy_rise", 32'(bus_e.rx_busy), 32'd1);
        hold(1, 1'b1, 12);
        check_eq("e_glitch_busy_fall", 32'(bus_e.rx_busy), 32'd0);
        hold(1, 1'b1, 32);
        check_eq("e_glitch_no_valid", vcyc[1] - v0, 32'd0);
        check_eq("e_glitch_no_pulses", (brk[1] - b0) + (ovr[1] - o0), 32'd0);
        check_eq("e_glitch_flags", 32'({bus_e.parity_err, bus_e.frame_err}), 32'd0);

        // Overrun, then accept in the DONE cycle of the next frame
        o0 = ovr[1];
        bus_e.rx_ready = 1'b0;
        send(1, 8'h11, 1'b0, 1'b1, 1'b1);
        send(1, 8'h22, 1'b0, 1'b1, 1'b0);
        hold(1, 1'b1, 32);
        check_eq("e_overrun_pulse_cycles", ovr[1] - o0, 32'd1);
        check_eq("e_overrun_held_byte", 32'(bus_e.rx_byte), 32'h11);
        check_eq("e_overrun_held_valid", 32'(bus_e.rx_valid), 32'd1);
        fork
            send(1, 8'h33, 1'b0, 1'b1, 1'b1);
            begin
                // DONE of an 11-bit frame spans the clock after rising edge 13+16*10
                repeat (13 + 16 * 10) @(posedge clk);
                #1 bus_e.rx_ready = 1'b1;
                @(posedge clk);
                #1 bus_e.rx_ready = 1'b0;
                check_eq("e_reload_valid", 32'(bus_e.rx_valid), 32'd1);
            end
        join
        check_eq("e_reload_no_overrun", ovr[1] - o0, 32'd1);
        check_eq("e_reload_byte", 32'(bus_e.rx_byte), 32'h33);
        check_eq("e_reload_valid_held", 32'(bus_e.rx_valid), 32'd1);
        bus_e.rx_ready = 1'b1;
        hold(1, 1'b1, 32);

        // Reset during data bit 4 of 0xFF with a frame held on the 8N1 instance
        bus_n.rx_ready = 1'b0;
        send(0, 8'h5A, 1'b0, 1'b1, 1'b0);
        hold(0, 1'b1, 16);
        check_eq("n_pre_reset_held", 32'({bus_n.rx_valid, bus_n.rx_byte}), 32'h15A);
        fork
            send(0, 8'hFF, 1'b0, 1'b1, 1'b0);
            begin
                repeat (16 * 5 + 5) @(posedge clk);
                #1 areset = 1'b1;
                @(posedge clk);
                #1 areset = 1'b0;
                check_eq("n_midframe_reset_outputs", 32'({bus_n.rx_byte, bus_n.rx_valid, bus_n.rx_busy,
                         bus_n.parity_err, bus_n.frame_err, bus_n.overrun_err, bus_n.break_det}), 32'd0);
            end
        join
        v0 = vcyc[0];
        bus_n.rx_ready = 1'b1;
        hold(0, 1'b1, 48);
        check_eq("n_after_reset_no_valid", vcyc[0] - v0, 32'd0);
        send(0, 8'h81, 1'b0, 1'b1, 1'b1);
        hold(0, 1'b1, 32);

        check_eq("n_scoreboard_drained", 32'(q_n.size()), 32'd0);
        check_eq("e_scoreboard_drained", 32'(q_e.size()), 32'd0);
        check_eq("n_no_overrun_or_break", ovr[0] + brk[0], 32'd0);
        check_eq("e_break_total", brk[1], 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
